// File: rtl/vga_pkg.sv
// vga_pkg: 640x480@60 timing defaults, FSM state type and coordinate width
// shared by the VGA sync generator files.
package vga_pkg;
    localparam int COORD_W      = 10;
    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;
    localparam int H_TOTAL      = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
    localparam int V_TOTAL      = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;
    typedef enum logic {IDLE, RUN} state_t;
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: generic two-flop synchronizer with asynchronous active-high reset.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic meta;
    always_ff @(posedge clk or posedge rst)
        if (rst) {q, meta} <= 2'b00;
        else     {q, meta} <= {meta, d};
endmodule

// File: rtl/vga_sync_gen.sv
// vga_sync_gen: VGA sync/coordinate generator clocked by the PLL, gated on PLL lock.
// Define VGA_FRAME_CNT_EN to add the frame_count output.
module vga_sync_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FP     = V_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF
) (
    input  logic               refclk,
    input  logic               rst,
    input  logic               pll_locked,
    output logic               hsync,
    output logic               vsync,
    output logic               video_on,
    output logic [COORD_W-1:0] pixel_col,
    output logic [COORD_W-1:0] pixel_row,
    output logic               frame_start
`ifdef VGA_FRAME_CNT_EN
    ,
    output logic [7:0]         frame_count
`endif
);
    localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam logic [COORD_W-1:0] H_LAST = COORD_W'(H_TOT - 1);
    localparam logic [COORD_W-1:0] V_LAST = COORD_W'(V_TOT - 1);
    localparam logic [COORD_W-1:0] H_VIS  = COORD_W'(H_ACTIVE);
    localparam logic [COORD_W-1:0] V_VIS  = COORD_W'(V_ACTIVE);
    localparam logic [COORD_W-1:0] HS_BEG = COORD_W'(H_ACTIVE + H_FP);
    localparam logic [COORD_W-1:0] HS_END = COORD_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [COORD_W-1:0] VS_BEG = COORD_W'(V_ACTIVE + V_FP);
    localparam logic [COORD_W-1:0] VS_END = COORD_W'(V_ACTIVE + V_FP + V_SYNC);

    state_t             state, next_state;
    logic               lock_s, run, h_last;
    logic [COORD_W-1:0] h_cnt, v_cnt, h_nxt, v_nxt;

    sync_2ff u_lock_sync (
        .clk (refclk),
        .rst (rst),
        .d   (pll_locked),
        .q   (lock_s)
    );

    always_ff @(posedge refclk or posedge rst)
        if (rst) state <= IDLE;
        else     state <= next_state;

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (lock_s) next_state = RUN;
            RUN:     if (!lock_s) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // The cycle lock_s changes already counts as the new state, so the first
    // frame_start lands one cycle after lock_s rises and idling is immediate on loss.
    always_comb begin
        run    = next_state == RUN;
        h_last = h_cnt == H_LAST;
        h_nxt  = h_last ? '0 : h_cnt + 1'b1;
        v_nxt  = h_last ? (v_cnt == V_LAST ? '0 : v_cnt + 1'b1) : v_cnt;
    end

    always_ff @(posedge refclk or posedge rst)
        if (rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else begin
            h_cnt <= run ? h_nxt : '0;
            v_cnt <= run ? v_nxt : '0;
        end

    always_ff @(posedge refclk or posedge rst)
        if (rst) begin
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            video_on    <= 1'b0;
            pixel_col   <= '0;
            pixel_row   <= '0;
            frame_start <= 1'b0;
        end else begin
            hsync       <= !(run && h_cnt >= HS_BEG && h_cnt < HS_END);
            vsync       <= !(run && v_cnt >= VS_BEG && v_cnt < VS_END);
            video_on    <= run && h_cnt < H_VIS && v_cnt < V_VIS;
            pixel_col   <= run ? h_cnt : '0;
            pixel_row   <= run ? v_cnt : '0;
            frame_start <= run && h_cnt == '0 && v_cnt == '0;
        end

`ifdef VGA_FRAME_CNT_EN
    // (0,0) while already in RUN only happens on a frame wrap, never on lock-up.
    always_ff @(posedge refclk or posedge rst)
        if (rst) frame_count <= '0;
        else if (run && state == RUN && h_cnt == '0 && v_cnt == '0) frame_count <= frame_count + 1'b1;
`endif
endmodule

// File: doc/vga_sync_gen.md
# vga_sync_gen

Generates 640x480 @ 60 Hz VGA timing from the 25 MHz pixel clock produced by the board PLL. It sits directly downstream of the PLL: clocked by the PLL output clock, it gates its operation on the PLL lock indication. It provides registered sync strobes and pixel coordinates to the game's pixel renderer and the VGA DAC pins.

## Interface
Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)

Ports:
- refclk  in  1  25 MHz pixel clock, driven from the PLL output clock
- rst  in  1  asynchronous, active-high reset
- pll_locked  in  1  PLL lock indication; asynchronous to refclk
- hsync  out  1  horizontal sync, active-low
- vsync  out  1  vertical sync, active-low
- video_on  out  1  high while the current pixel is in the visible region
- pixel_col  out  10  current column, 0..H_TOTAL-1
- pixel_row  out  10  current row, 0..V_TOTAL-1
- frame_start  out  1  one-cycle pulse at pixel (0,0)
- frame_count  out  8  frames completed; present only with VGA_FRAME_CNT_EN

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP = 800; V_TOTAL = 525. Both totals must be ≤1024 so they fit the 10-bit counters. The counters are h_cnt and v_cnt.
- pll_locked passes through a 2-flop synchronizer to give lock_s.
- States:
  - IDLE: counters held at 0; outputs at their idle values.
  - RUN: counters advance.
- Transitions:
  - IDLE→RUN on the first cycle lock_s=1.
  - RUN→IDLE on the first cycle lock_s=0. Counters clear that same cycle. This applies mid-line and mid-frame; no frame completion is awaited.
- In RUN, h_cnt increments every cycle and wraps from H_TOTAL-1 to 0. v_cnt increments when h_cnt wraps, and wraps from V_TOTAL-1 to 0.
- Decode (all outputs registered from the counter values):
  - hsync=0 when H_ACTIVE+H_FP ≤ h_cnt < H_ACTIVE+H_FP+H_SYNC (656..751).
  - vsync=0 when V_ACTIVE+V_FP ≤ v_cnt < V_ACTIVE+V_FP+V_SYNC (490..491).
  - video_on=1 when h_cnt<H_ACTIVE and v_cnt<V_ACTIVE.
  - pixel_col=h_cnt and pixel_row=v_cnt. Downstream consumers must qualify both with video_on.
  - frame_start=1 when h_cnt=0 and v_cnt=0 in RUN.
- Idle and reset values: hsync=1, vsync=1, video_on=0, pixel_col=0, pixel_row=0, frame_start=0, frame_count=0, state=IDLE, synchronizer flops=0.

## Timing
- Output latency is 1 cycle: the outputs at edge n+1 reflect the counter values at edge n.
- pll_locked rising at edge k:
  - lock_s=1 at edge k+2; counters are (0,0) there.
  - frame_start=1 and video_on=1 at edge k+3.
  - pixel_col=1 at edge k+4.
- pll_locked falling at edge k: lock_s=0 at edge k+2; all outputs are at idle values from edge k+3.
- Line period is 800 cycles; frame period is 420000 cycles. hsync low for 96 cycles per line; vsync low for 1600 cycles per frame.
- Assertion of rst clears all flops immediately, with no clock needed. After release, the block re-enters via the lock path (minimum 3 cycles to the first frame_start).

## Configuration
- VGA_FRAME_CNT_EN defined:
  - frame_count port exists.
  - It increments by 1 (mod 256) on the cycle its registered value would coincide with v_cnt wrapping 524→0, i.e. it changes in the same cycle frame_start pulses.
  - It is held, not cleared, on RUN→IDLE. It is cleared only by rst.
- VGA_FRAME_CNT_EN undefined: no frame_count port and no counter logic.

## Structure
- Shared package vga_pkg holds:
  - 640x480 timing constants (H_*/V_* defaults, H_TOTAL, V_TOTAL);
  - the state typedef {IDLE, RUN};
  - the coordinate width constant (10).
- One sub-module, sync_2ff: a generic 2-flop synchronizer with asynchronous reset. It is instantiated once, for pll_locked.

## Test plan
- Reset and idle: rst=1, pll_locked=0 for 10 cycles → hsync=1, vsync=1, video_on=0, pixel_col=0, pixel_row=0, frame_start=0 throughout.
- Lock-up: release rst, raise pll_locked at edge k → frame_start=1 exactly at edge k+3, with pixel_col=0 and pixel_row=0; pixel_col=1 at edge k+4.
- Horizontal timing, one full line:
  - video_on high for 640 cycles;
  - hsync falls when pixel_col=656 and stays low 96 cycles;
  - pixel_col wraps 799→0 and pixel_row increments.
- Vertical timing:
  - frame_start pulses repeat every 420000 cycles;
  - vsync is low for rows 490..491 (1600 cycles);
  - video_on=0 for rows 480..524.
- Lock loss mid-frame: drop pll_locked at row 200, col 300 → outputs idle 3 cycles later; re-raise → frame_start 3 cycles after the rise, restarting at (0,0).
- With VGA_FRAME_CNT_EN: run 3 frames → frame_count steps 0→1→2→3, coincident with frame_start. Then drop lock → frame_count holds at 3. Then assert rst → frame_count=0.
